// File: rtl/jt89_tone_bank_if.sv
//------------------------------------------------------------------------------
// Module      : jt89_tone_bank_if
// Description : Control/write bus and waveform outputs of jt89_tone_bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface jt89_tone_bank_if #(
  parameter int CH = 3,
  parameter int W  = 10,
  parameter int AW = 2
);
  logic          clk_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] out;
  logic [CH-1:0] tick;

  modport master (output clk_en, wr_en, wr_addr, wr_data, input out, tick);
  modport slave  (input clk_en, wr_en, wr_addr, wr_data, output out, tick);
endinterface

`default_nettype wire

// File: rtl/jt89_tone_bank.sv
//------------------------------------------------------------------------------
// Module      : jt89_tone_bank
// Description : CH square-wave tone channels sharing one round-robin
//               decrement/compare datapath. Optional JT89_TONE_PHASE_RST_EN:
//               a period write also restarts the channel phase.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jt89_tone_bank #(
  parameter int CH   = 3,
  parameter int W    = 10,
  parameter int AW   = 2,
  parameter int DEAF = 5
) (
  input  wire logic       clk,
  input  wire logic       rst,
  jt89_tone_bank_if.slave bus
);

  localparam logic [AW-1:0] c_last = AW'(CH - 1);
  localparam logic [W-1:0]  c_deaf = W'(DEAF);
  localparam logic [W-1:0]  c_one  = W'(1);

  logic [W-1:0]  r_period [CH];
  logic [W-1:0]  r_cnt    [CH];
  logic [CH-1:0] r_out;
  logic [CH-1:0] r_tick;
  logic [AW-1:0] r_slot;

  logic [W-1:0]  w_per;
  logic [W-1:0]  w_cnt;
  logic [W-1:0]  w_reload_val;
  logic          w_deaf;
  logic          w_expire;

  // Shared datapath: select the period/count of the channel in service.
  always_comb begin
    w_per = '0;
    w_cnt = '0;
    for (int i = 0; i < CH; i++) begin
      if (r_slot == AW'(i)) begin
        w_per = r_period[i];
        w_cnt = r_cnt[i];
      end
    end
  end

  assign w_deaf       = (DEAF > 0) && (w_per <= c_deaf);
  assign w_expire     = (w_cnt <= c_one);
  assign w_reload_val = (w_per == '0) ? c_one : w_per;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        r_period[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_out  <= '0;
      r_tick <= '0;
      r_slot <= '0;
    end else begin
      r_tick <= '0;
      if (bus.clk_en) begin
        r_slot <= (r_slot == c_last) ? '0 : r_slot + 1'b1;
        for (int i = 0; i < CH; i++) begin
          if (r_slot == AW'(i)) begin
            if (w_deaf) begin
              r_out[i] <= 1'b1;
            end else if (w_expire) begin
              r_cnt[i]  <= w_reload_val;
              r_out[i]  <= ~r_out[i];
              r_tick[i] <= 1'b1;
            end else begin
              r_cnt[i] <= w_cnt - c_one;
            end
          end
        end
      end
      // Writes come last so a phase restart overrides a same-edge service.
      if (bus.wr_en) begin
        for (int i = 0; i < CH; i++) begin
          if (bus.wr_addr == AW'(i)) begin
            r_period[i] <= bus.wr_data;
`ifdef JT89_TONE_PHASE_RST_EN
            r_cnt[i]  <= '0;
            r_out[i]  <= 1'b0;
            r_tick[i] <= 1'b0;
`endif
          end
        end
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_jt89_tone_bank.sv
//------------------------------------------------------------------------------
// Module      : tb_jt89_tone_bank
// Description : Directed vector bench for jt89_tone_bank (CH=3 and CH=4 units).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_jt89_tone_bank;

  localparam int W  = 10;
  localparam int AW = 2;
`ifdef JT89_TONE_PHASE_RST_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt89_tone_bank_if #(.CH(3), .W(W), .AW(AW)) bus_a ();
  jt89_tone_bank_if #(.CH(4), .W(W), .AW(AW)) bus_b ();

  jt89_tone_bank #(.CH(3), .W(W), .AW(AW), .DEAF(5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  jt89_tone_bank #(.CH(4), .W(W), .AW(AW), .DEAF(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            n;
    logic [2:0]    out;
    logic [2:0]    tick;
  } vec_t;

  vec_t vecs [17];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] tk;
  logic       exp2;
  logic [3:0] tkb;
  logic [3:0] exp_b;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      bus_a.clk_en  = vecs[i].en;
      bus_a.wr_en   = vecs[i].wr;
      bus_a.wr_addr = vecs[i].addr;
      bus_a.wr_data = vecs[i].data;
      for (int j = 0; j < vecs[i].n; j++) begin
        step();
        bus_a.wr_en = 1'b0;
      end
      check($sformatf("%s vec%0d out", tag, i), 16'(bus_a.out), 16'(vecs[i].out));
      check($sformatf("%s vec%0d tick", tag, i), 16'(bus_a.tick), 16'(vecs[i].tick));
    end
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Edge numbers E<n> in the notes count clk_en=1 edges after the period write.
    //          en    wr    addr   data     n   out                      tick
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 10'd8,   1,  3'b000,                  3'b000}; // write ch0=8
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  3'b001,                  3'b001}; // E1 ch0 rises
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  3'b011,                  3'b000}; // E2 ch1 deaf
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  3'b111,                  3'b000}; // E3 ch2 deaf
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 10'd0,   21, 3'b111,                  3'b000}; // E24
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  3'b110,                  3'b001}; // E25 toggle
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 10'd0,   23, 3'b110,                  3'b000}; // E48
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  3'b111,                  3'b001}; // E49 toggle
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 10'd3,   1,  (PH ? 3'b101 : 3'b111), 3'b000}; // E50 ch1=3
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 10'd0,   4,  3'b111,                  3'b000}; // E54
    vecs[10] = '{1'b1, 1'b1, 2'd1, 10'd10,  1,  (PH ? 3'b101 : 3'b111), 3'b000}; // E55 ch1=10
    vecs[11] = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  (PH ? 3'b111 : 3'b101), 3'b010}; // E56 resume
    vecs[12] = '{1'b1, 1'b0, 2'd0, 10'd0,   16, (PH ? 3'b111 : 3'b101), 3'b000}; // E72
    vecs[13] = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  (PH ? 3'b110 : 3'b100), 3'b001}; // E73
    vecs[14] = '{1'b1, 1'b1, 2'd3, 10'd100, 1,  (PH ? 3'b110 : 3'b100), 3'b000}; // E74 bad addr
    vecs[15] = '{1'b1, 1'b0, 2'd0, 10'd0,   11, (PH ? 3'b110 : 3'b100), 3'b000}; // E85
    vecs[16] = '{1'b1, 1'b0, 2'd0, 10'd0,   1,  (PH ? 3'b100 : 3'b110), 3'b010}; // E86

    bus_a.clk_en = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.clk_en = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;

    #12;
    check("reset out a", 16'(bus_a.out), 16'h0);
    check("reset tick a", 16'(bus_a.tick), 16'h0);
    check("reset out b", 16'(bus_b.out), 16'h0);
    step();
    rst = 1'b0;

    run_vecs(0, 16, "run1");

    // Asynchronous reset between edges while out/tick are non-zero.
    #1;
    rst = 1'b1;
    #1;
    check("async rst out", 16'(bus_a.out), 16'h0);
    check("async rst tick", 16'(bus_a.tick), 16'h0);
    step();
    rst = 1'b0;
    run_vecs(0, 7, "rerun");

    // clk_en one clk in four, ch2 period 6.
    pulse_reset();
    bus_a.clk_en  = 1'b0;
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 2'd2;
    bus_a.wr_data = 10'd6;
    step();
    bus_a.wr_en = 1'b0;
    exp2 = 1'b0;
    for (int c = 0; c < 160; c++) begin
      bus_a.clk_en = (c % 4 == 0);
      step();
      tk = (c == 8 || c == 80 || c == 152) ? 3'b100 : 3'b000;
      if (tk[2]) exp2 = ~exp2;
      check($sformatf("en4 tick c%0d", c), 16'(bus_a.tick), 16'(tk));
      check($sformatf("en4 out2 c%0d", c), 16'(bus_a.out[2]), 16'(exp2));
    end

    // CH=4, DEAF=0: period 0 behaves as 1; write to ch3 at edge 5 while out[3]=1.
    bus_a.clk_en = 1'b0;
    pulse_reset();
    bus_b.clk_en = 1'b1;
    exp_b = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      bus_b.wr_en   = (k == 5);
      bus_b.wr_addr = 2'd3;
      bus_b.wr_data = '0;
      step();
      tkb   = 4'(1 << ((k - 1) % 4));
      exp_b = exp_b ^ tkb;
      if (PH && k == 5) exp_b[3] = 1'b0;
      check($sformatf("b out k%0d", k), 16'(bus_b.out), 16'(exp_b));
      check($sformatf("b tick k%0d", k), 16'(bus_b.tick), 16'(tkb));
    end
    bus_b.wr_en  = 1'b0;
    bus_b.clk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
